// File: rtl/univ_shift_reg_pkg.sv
// Shared definitions for the universal shift register: operation encodings
// and the shift-counter width helper used by the top and the frame counter.
package univ_shift_reg_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHL  = 2'b01,
        MODE_SHR  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 64;

    // Counter width for a register of the given length, never below one bit.
    function automatic int cnt_width(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/shift_frame_cnt.sv
// Counts shifts within a frame of WIDTH shifts and pulses frame_done on the
// shift that completes the frame; clr restarts the frame without a pulse.
module shift_frame_cnt
    import univ_shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          step,
    output logic [CW-1:0] shift_cnt,
    output logic          frame_done
);

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_cnt;
    logic          r_frame_done;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    // NOTE: registered state uses non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else if (step) begin
            r_cnt        <= w_last ? '0 : r_cnt + CW'(1);
            r_frame_done <= w_last;
        end else begin
            r_frame_done <= 1'b0;
        end
    end

    assign shift_cnt  = r_cnt;
    assign frame_done = r_frame_done;

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left, shift right, parallel load,
// with serial outputs and a frame counter that pulses every WIDTH shifts.
module univ_shift_reg
    import univ_shift_reg_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CW    = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout_msb,
    output logic             sout_lsb,
    output logic [CW-1:0]    shift_cnt,
    output logic             frame_done
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic             w_step;
    logic             w_clr;
    mode_e            w_mode;

    assign w_mode = mode_e'(mode);

    // NOTE: every always_comb output gets a default before the case so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        w_q_next = r_q;
        w_step   = 1'b0;
        w_clr    = 1'b0;
        if (en) begin
            case (w_mode)
                MODE_SHL: begin
                    w_q_next = {r_q[WIDTH-2:0], sin_lsb};
                    w_step   = 1'b1;
                end
                MODE_SHR: begin
                    w_q_next = {sin_msb, r_q[WIDTH-1:1]};
                    w_step   = 1'b1;
                end
                MODE_LOAD: begin
                    w_q_next = pdata;
                    w_clr    = 1'b1;
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else begin
            r_q <= w_q_next;
        end
    end

    shift_frame_cnt #(
        .WIDTH(WIDTH)
    ) u_frame_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_clr),
        .step      (w_step),
        .shift_cnt (shift_cnt),
        .frame_done(frame_done)
    );

    // Serial outputs come from the register only, never from the inputs.
    assign q        = r_q;
    assign sout_msb = r_q[WIDTH-1];
    assign sout_lsb = r_q[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: a 4-bit and an 8-bit instance share one clock,
// a reference model feeds a scoreboard, and each scenario adds directed checks.
module tb_univ_shift_reg;
    import univ_shift_reg_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_a, en_a, sl_a, sm_a;
    logic [1:0] mode_a;
    logic [3:0] pd_a, q_a;
    logic       so_msb_a, so_lsb_a, fd_a;
    logic [1:0] cnt_a;

    logic       rst_b, en_b, sl_b, sm_b;
    logic [1:0] mode_b;
    logic [7:0] pd_b, q_b;
    logic       so_msb_b, so_lsb_b, fd_b;
    logic [2:0] cnt_b;

    univ_shift_reg #(.WIDTH(4)) dut_a (
        .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a),
        .sin_lsb(sl_a), .sin_msb(sm_a), .pdata(pd_a), .q(q_a),
        .sout_msb(so_msb_a), .sout_lsb(so_lsb_a),
        .shift_cnt(cnt_a), .frame_done(fd_a)
    );

    univ_shift_reg #(.WIDTH(8)) dut_b (
        .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b),
        .sin_lsb(sl_b), .sin_msb(sm_b), .pdata(pd_b), .q(q_b),
        .sout_msb(so_msb_b), .sout_lsb(so_lsb_b),
        .shift_cnt(cnt_b), .frame_done(fd_b)
    );

    typedef struct {
        int          inst;
        logic [63:0] q;
        int          cnt;
        logic        fd;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] mq[2];
    int          mc[2];
    logic        mf[2];
    int          mw[2] = '{4, 8};
    int          n_tests = 0;
    int          n_fail  = 0;
    string       tname   = "init";

    // Reference behaviour of one instance for one rising edge.
    task automatic model_step(input int k, input logic r, input logic e,
                              input logic [1:0] m, input logic sl,
                              input logic sm, input logic [63:0] pd);
        logic [63:0] mask;
        mask = (64'd1 << mw[k]) - 64'd1;
        if (r) begin
            mq[k] = '0; mc[k] = 0; mf[k] = 1'b0;
        end else if (!e || m == 2'b00) begin
            mf[k] = 1'b0;
        end else if (m == 2'b11) begin
            mq[k] = pd & mask; mc[k] = 0; mf[k] = 1'b0;
        end else begin
            if (m == 2'b01) mq[k] = ((mq[k] << 1) | 64'(sl)) & mask;
            else            mq[k] = (mq[k] >> 1) | (64'(sm) << (mw[k] - 1));
            if (mc[k] == mw[k] - 1) begin
                mc[k] = 0; mf[k] = 1'b1;
            end else begin
                mc[k] = mc[k] + 1; mf[k] = 1'b0;
            end
        end
    endtask

    // Drives one edge on instance k (the other holds), then pops and compares.
    task automatic cycle(input int k, input logic r, input logic e,
                         input logic [1:0] m, input logic sl, input logic sm,
                         input logic [63:0] pd);
        exp_t        ex;
        logic [63:0] aq;
        int          ac;
        logic        af, amsb, alsb;
        if (k == 0) begin
            rst_a = r; en_a = e; mode_a = m; sl_a = sl; sm_a = sm; pd_a = pd[3:0];
            rst_b = 1'b0; en_b = 1'b0; mode_b = 2'b00;
        end else begin
            rst_b = r; en_b = e; mode_b = m; sl_b = sl; sm_b = sm; pd_b = pd[7:0];
            rst_a = 1'b0; en_a = 1'b0; mode_a = 2'b00;
        end
        model_step(k, r, e, m, sl, sm, pd);
        model_step(1 - k, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 64'd0);
        sb.push_back('{k, mq[k], mc[k], mf[k]});
        @(posedge clk);
        #1;
        ex = sb.pop_front();
        if (ex.inst == 0) begin
            aq = 64'(q_a); ac = int'(cnt_a); af = fd_a; amsb = so_msb_a; alsb = so_lsb_a;
        end else begin
            aq = 64'(q_b); ac = int'(cnt_b); af = fd_b; amsb = so_msb_b; alsb = so_lsb_b;
        end
        n_tests += 5;
        if (aq !== ex.q) begin
            n_fail++; $display("FAIL %s q inst%0d: got %h want %h", tname, ex.inst, aq, ex.q);
        end
        if (ac !== ex.cnt) begin
            n_fail++; $display("FAIL %s shift_cnt inst%0d: got %0d want %0d", tname, ex.inst, ac, ex.cnt);
        end
        if (af !== ex.fd) begin
            n_fail++; $display("FAIL %s frame_done inst%0d: got %b want %b", tname, ex.inst, af, ex.fd);
        end
        if (amsb !== ex.q[mw[ex.inst]-1]) begin
            n_fail++; $display("FAIL %s sout_msb inst%0d: got %b want %b", tname, ex.inst, amsb, ex.q[mw[ex.inst]-1]);
        end
        if (alsb !== ex.q[0]) begin
            n_fail++; $display("FAIL %s sout_lsb inst%0d: got %b want %b", tname, ex.inst, alsb, ex.q[0]);
        end
    endtask

    task automatic test_reset();
        tname = "reset";
        cycle(0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 64'hF);
        cycle(1, 1'b1, 1'b1, 2'b11, 1'b1, 1'b1, 64'hFF);
        n_tests++;
        if (q_b !== 8'h00 || cnt_b !== 3'd0 || fd_b !== 1'b0) begin
            n_fail++; $display("FAIL reset_state: got q=%h cnt=%0d fd=%b want 00/0/0", q_b, cnt_b, fd_b);
        end
    endtask

    task automatic test_serial_in();
        logic bits[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        tname = "serial_in";
        cycle(0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 4; i++) cycle(0, 1'b0, 1'b1, 2'b01, bits[i], 1'b0, 64'd0);
        n_tests++;
        if (q_a !== 4'b1011 || fd_a !== 1'b1) begin
            n_fail++; $display("FAIL serial_in_frame: got q=%b fd=%b want 1011/1", q_a, fd_a);
        end
        cycle(0, 1'b0, 1'b0, 2'b01, 1'b0, 1'b0, 64'd0);
        n_tests++;
        if (fd_a !== 1'b0 || q_a !== 4'b1011) begin
            n_fail++; $display("FAIL serial_in_hold: got q=%b fd=%b want 1011/0", q_a, fd_a);
        end
    endtask

    task automatic test_load_shr();
        int exp_seq[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
        int pulses = 0;
        tname = "load_shr";
        cycle(1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 64'hA5);
        for (int i = 0; i < 8; i++) begin
            n_tests++;
            if (int'(so_lsb_b) !== exp_seq[i]) begin
                n_fail++; $display("FAIL shr_sout_lsb[%0d]: got %b want %0d", i, so_lsb_b, exp_seq[i]);
            end
            cycle(1, 1'b0, 1'b1, 2'b10, 1'b1, 1'b0, 64'd0);
            if (fd_b === 1'b1) pulses++;
        end
        n_tests++;
        if (q_b !== 8'h00 || pulses != 1) begin
            n_fail++; $display("FAIL shr_frame: got q=%h pulses=%0d want 00/1", q_b, pulses);
        end
    endtask

    task automatic test_load_restart();
        tname = "load_restart";
        cycle(0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'd0);
        cycle(0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 64'd0);
        cycle(0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 64'd0);
        cycle(0, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, 64'h3);
        n_tests++;
        if (cnt_a !== 2'd0 || q_a !== 4'h3) begin
            n_fail++; $display("FAIL load_clears_cnt: got cnt=%0d q=%h want 0/3", cnt_a, q_a);
        end
        for (int i = 1; i <= 4; i++) begin
            cycle(0, 1'b0, 1'b1, (i[0] ? 2'b10 : 2'b01), 1'b0, 1'b1, 64'd0);
            n_tests++;
            if (fd_a !== (i == 4)) begin
                n_fail++; $display("FAIL post_load_shift%0d_fd: got %b want %b", i, fd_a, (i == 4));
            end
        end
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        tname = "reset_mid";
        for (int i = 0; i < 3; i++) cycle(0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 64'd0);
        cycle(0, 1'b1, 1'b1, 2'b01, 1'b1, 1'b0, 64'd0);
        n_tests++;
        if (q_a !== 4'h0 || cnt_a !== 2'd0 || fd_a !== 1'b0) begin
            n_fail++; $display("FAIL mid_reset: got q=%h cnt=%0d fd=%b want 0/0/0", q_a, cnt_a, fd_a);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1'b0, 1'b1, 2'b01, 1'b1, 1'b0, 64'd0);
            if (fd_a === 1'b1) pulses++;
        end
        n_tests++;
        if (pulses != 1 || fd_a !== 1'b1) begin
            n_fail++; $display("FAIL after_reset_pulses: got %0d (last fd=%b) want 1 on 4th", pulses, fd_a);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] hq;
        logic [1:0] hc;
        tname = "back_to_back";
        cycle(0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 64'd0);
        for (int i = 1; i <= 12; i++) begin
            cycle(0, 1'b0, 1'b1, 2'b01, 1'($urandom_range(1)), 1'b0, 64'd0);
            n_tests++;
            if (fd_a !== (i % 4 == 0)) begin
                n_fail++; $display("FAIL b2b_shift%0d_fd: got %b want %b", i, fd_a, (i % 4 == 0));
            end
            if (i == 6) begin
                hq = q_a; hc = cnt_a;
                cycle(0, 1'b0, 1'b0, 2'b01, 1'b1, 1'b0, 64'd0);
                cycle(0, 1'b0, 1'b0, 2'b10, 1'b0, 1'b1, 64'd0);
                n_tests++;
                if (q_a !== hq || cnt_a !== hc) begin
                    n_fail++; $display("FAIL b2b_freeze: got q=%h cnt=%0d want %h/%0d", q_a, cnt_a, hq, hc);
                end
            end
        end
    endtask

    task automatic test_random_mix();
        tname = "random_mix";
        for (int i = 0; i < 80; i++) begin
            cycle(i % 2, ($urandom_range(29) == 0), ($urandom_range(5) != 0),
                  2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  {$urandom, $urandom});
        end
    endtask

    initial begin
        rst_a = 1'b1; en_a = 1'b0; mode_a = 2'b00; sl_a = 1'b0; sm_a = 1'b0; pd_a = '0;
        rst_b = 1'b1; en_b = 1'b0; mode_b = 2'b00; sl_b = 1'b0; sm_b = 1'b0; pd_b = '0;
        for (int k = 0; k < 2; k++) begin
            mq[k] = '0; mc[k] = 0; mf[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        test_reset();
        test_serial_in();
        test_load_shr();
        test_load_restart();
        test_reset_mid();
        test_back_to_back();
        test_random_mix();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
